// File: rtl/seq_divider_asmd.sv
// seq_divider_asmd: sequential restoring divider (ASMD style).
// A controller FSM drives a shift/subtract datapath that reuses one
// (M+1)-bit subtractor for N cycles, producing one quotient bit per cycle.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset (aborts any operation)
//   start    - request, only sampled in IDLE or DONE
//   sgn      - (SIGNED_DIV_EN only) treat A/B as two's complement
//   A [N-1:0]- dividend, captured on the accepting edge
//   B [M-1:0]- divisor, captured on the accepting edge
//   Q [N-1:0]- quotient, registered, held until the next result
//   R [M-1:0]- remainder, registered, held until the next result
//   busy     - high while iterating (CALC, and FIX when present)
//   done     - one-cycle pulse when Q/R/div_zero are valid
//   div_zero - set with done when the captured divisor was zero
//
// Optional feature: define SIGNED_DIV_EN to add the sgn input and a FIX
// state that applies result signs (truncation toward zero, R follows A).
module seq_divider_asmd #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef SIGNED_DIV_EN
  input  logic         sgn,
`endif
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic [N-1:0] Q,
  output logic [M-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE, FIX} state_t;
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;   // dividend in, quotient bits shift in at LSB
  logic [M-1:0]   dvs_q, dvs_d;
  logic [M-1:0]   p_q, p_d;       // partial remainder; guard bit lives only in p_sh/t
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   q_q, q_d;
  logic [M-1:0]   r_q, r_d;
  logic           dz_q, dz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [M:0]     p_sh, t;
  logic [N-1:0]   a_mag;
  logic [M-1:0]   b_mag;

`ifdef SIGNED_DIV_EN
  logic sgn_q, sgn_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;

  function automatic logic [N-1:0] mag_n(input logic signed [N-1:0] v, input logic s);
    // Most-negative input maps to 2^(N-1), which still fits unsigned N bits.
    return (s && (v < 0)) ? N'(-v) : N'(v);
  endfunction

  function automatic logic [M-1:0] mag_m(input logic signed [M-1:0] v, input logic s);
    return (s && (v < 0)) ? M'(-v) : M'(v);
  endfunction

  assign a_mag = mag_n(A, sgn);
  assign b_mag = mag_m(B, sgn);
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
`ifdef SIGNED_DIV_EN
    sgn_d   = sgn_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    // Trial subtraction: t[M]=1 means the shifted remainder is below B.
    p_sh = {p_q, dvd_q[N-1]};
    t    = p_sh - {1'b0, dvs_q};

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dz_d = (B == '0);
          if (B == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = '0;
          end else begin
            state_d = CALC;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            p_d     = '0;
            cnt_d   = CNT_LOAD;
`ifdef SIGNED_DIV_EN
            sgn_d   = sgn;
            neg_q_d = sgn & (A[N-1] ^ B[M-1]);
            neg_r_d = sgn & A[N-1];
`endif
          end
        end
      end
      CALC: begin
        p_d   = t[M] ? p_sh[M-1:0] : t[M-1:0];
        dvd_d = {dvd_q[N-2:0], ~t[M]};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
`ifdef SIGNED_DIV_EN
          if (sgn_q) begin
            state_d = FIX;
          end else begin
            state_d = DONE;
            q_d     = dvd_d;
            r_d     = p_d;
          end
`else
          state_d = DONE;
          q_d     = dvd_d;
          r_d     = p_d;
`endif
        end
      end
`ifdef SIGNED_DIV_EN
      FIX: begin
        // Unsigned magnitudes are complete; apply signs. -128/-1 wraps to -128.
        q_d     = neg_q_q ? N'(-dvd_q) : dvd_q;
        r_d     = neg_r_q ? M'(-p_q) : p_q;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef SIGNED_DIV_EN
    busy_d = (state_d == CALC) || (state_d == FIX);
`else
    busy_d = (state_d == CALC);
`endif
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SIGNED_DIV_EN
      sgn_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SIGNED_DIV_EN
      sgn_q   <= sgn_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign Q        = q_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
